// File: rtl/mem_bist_pkg.sv
// Shared types for the March C- BIST controller: FSM state encoding, the
// element count and the march table that drives the address direction and
// the read/write operations of each element.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int         NUM_ELEMS = 6;
    localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEMS - 1);

    // One march element. Values are single bits because the backgrounds are
    // solid all-0 / all-1 words; callers replicate them to the data width.
    typedef struct packed {
        logic down;       // 1: DEPTH-1 -> 0, 0: 0 -> DEPTH-1
        logic has_read;
        logic rd_val;
        logic has_write;
        logic wr_val;
    } march_elem_t;

    // March C-: up(w0) up(r0,w1) up(r1,w0) dn(r0,w1) dn(r1,w0) up(r0)
    function automatic march_elem_t march_elem(input logic [2:0] idx);
        march_elem_t e;
        e = '0;
        case (idx)
            3'd0: e = '{down: 1'b0, has_read: 1'b0, rd_val: 1'b0, has_write: 1'b1, wr_val: 1'b0};
            3'd1: e = '{down: 1'b0, has_read: 1'b1, rd_val: 1'b0, has_write: 1'b1, wr_val: 1'b1};
            3'd2: e = '{down: 1'b0, has_read: 1'b1, rd_val: 1'b1, has_write: 1'b1, wr_val: 1'b0};
            3'd3: e = '{down: 1'b1, has_read: 1'b1, rd_val: 1'b0, has_write: 1'b1, wr_val: 1'b1};
            3'd4: e = '{down: 1'b1, has_read: 1'b1, rd_val: 1'b1, has_write: 1'b1, wr_val: 1'b0};
            3'd5: e = '{down: 1'b0, has_read: 1'b1, rd_val: 1'b0, has_write: 1'b0, wr_val: 1'b0};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mem_bist_march_if.sv
// Memory-side port bundle between the BIST controller and the test memory.
// master: controller (drives strobes, address, write data; takes read data).
// slave:  memory (takes strobes, address, write data; returns registered read data).
interface mem_bist_march_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              mem_write_en;
    logic              mem_read_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        output mem_write_en,
        output mem_read_en,
        output mem_addr,
        output mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  mem_write_en,
        input  mem_read_en,
        input  mem_addr,
        input  mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/mem_bist_addr_gen.sv
// Loadable up/down address counter with terminal-address flag.
// Latency: load/step take effect on the next edge; term_o is combinational.
// Backpressure: none; the FSM steps it only when an address is finished.
// Ports: clk/rst; load_i + load_down_i reload to DEPTH-1 (down) or 0 (up);
//        step_i moves one address in direction down_i; addr_o current
//        address; term_o high on the last address of the current direction.
module mem_bist_addr_gen #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              load_down_i,
    input  logic              step_i,
    input  logic              down_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              term_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_down_i ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
        end else if (step_i) begin
            addr_d = down_i ? (addr_q - 1'b1) : (addr_q + 1'b1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign term_o = down_i ? (addr_q == {ADDR_W{1'b0}}) : (addr_q == {ADDR_W{1'b1}});

endmodule

// File: rtl/mem_bist_march.sv
// March C- BIST controller owning the test memory ports during a run.
// Latency: 1 cycle start->first write; 3840 busy cycles for a passing 256-deep run.
// Backpressure: none; memory is assumed to accept one op per cycle, read data 1 cycle later.
// Ports: clk/rst; start request (honoured in IDLE/DONE); mem master port;
//        busy/done/fail status; fail_addr/fail_data/fail_elem first-failure diagnostics.
module mem_bist_march
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    mem_bist_march_if.master  mem,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [2:0]        fail_elem
);

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic [2:0]        fail_elem_q, fail_elem_d;

    logic              ag_load;
    logic              ag_load_down;
    logic              ag_step;
    logic [ADDR_W-1:0] addr;
    logic              addr_term;

    march_elem_t       cur;
    logic [2:0]        elem_nxt;
    logic              mismatch;

    assign cur      = march_elem(elem_q);
    assign elem_nxt = elem_q + 3'd1;
    assign mismatch = (mem.mem_read_data != {DATA_W{cur.rd_val}});

    mem_bist_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .load_i      (ag_load),
        .load_down_i (ag_load_down),
        .step_i      (ag_step),
        .down_i      (cur.down),
        .addr_o      (addr),
        .term_o      (addr_term)
    );

    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        fail_d       = fail_q;
        fail_addr_d  = fail_addr_q;
        fail_data_d  = fail_data_q;
        fail_elem_d  = fail_elem_q;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_WRITE;
                    elem_d      = 3'd0;
                    ag_load     = 1'b1;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    fail_elem_d = '0;
                end
            end

            ST_WRITE: begin
                if (addr_term) begin
                    // Write is always the last op of an element that has one,
                    // so the terminal write hands over to the next element.
                    elem_d       = elem_nxt;
                    ag_load      = 1'b1;
                    ag_load_down = march_elem(elem_nxt).down;
                    state_d      = march_elem(elem_nxt).has_read ? ST_READ : ST_WRITE;
                end else begin
                    ag_step = 1'b1;
                    state_d = cur.has_read ? ST_READ : ST_WRITE;
                end
            end

            ST_READ: begin
                state_d = ST_CHECK;
            end

            ST_CHECK: begin
                if (mismatch) begin
                    state_d     = ST_DONE;
                    fail_d      = 1'b1;
                    fail_addr_d = addr;
                    fail_data_d = mem.mem_read_data;
                    fail_elem_d = elem_q;
                end else if (cur.has_write) begin
                    state_d = ST_WRITE;
                end else if (addr_term) begin
                    if (elem_q == LAST_ELEM) begin
                        state_d = ST_DONE;
                    end else begin
                        elem_d       = elem_nxt;
                        ag_load      = 1'b1;
                        ag_load_down = march_elem(elem_nxt).down;
                        state_d      = march_elem(elem_nxt).has_read ? ST_READ : ST_WRITE;
                    end
                end else begin
                    ag_step = 1'b1;
                    state_d = ST_READ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            elem_q      <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_elem_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            fail_elem_q <= fail_elem_d;
        end
    end

    // Memory-side outputs decode purely from registered state so reset
    // silences them immediately, without waiting for a clock.
    assign busy               = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_CHECK);
    assign done               = (state_q == ST_DONE);
    assign mem.mem_write_en   = (state_q == ST_WRITE);
    assign mem.mem_read_en    = (state_q == ST_READ);
    assign mem.mem_addr       = busy ? addr : '0;
    assign mem.mem_write_data = (state_q == ST_WRITE) ? {DATA_W{cur.wr_val}} : '0;

    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign fail_elem = fail_elem_q;

endmodule

// File: tb/tb_mem_bist_march.sv
// Bench for mem_bist_march: behavioural 256x8 memory with one injectable
// stuck-at cell, a table of fault vectors, a strobe-order monitor, and
// hand-written sequences for reset and start-handling corner cases.
module tb_mem_bist_march;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       fail;
    logic [7:0] fail_addr;
    logic [7:0] fail_data;
    logic [2:0] fail_elem;

    mem_bist_march_if #(.ADDR_W(8), .DATA_W(8)) mem_if ();

    mem_bist_march #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem       (mem_if),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .fail_elem (fail_elem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- memory model with one stuck-at cell ----------------
    logic [7:0] mem [256];
    logic [7:0] rdata_q;
    logic [7:0] flt_addr;
    logic [7:0] flt_sa1;
    logic [7:0] flt_sa0;
    logic       fill_req;
    logic [7:0] fill_val;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= fill_val;
        end else if (mem_if.mem_write_en) begin
            if (mem_if.mem_addr == flt_addr)
                mem[mem_if.mem_addr] <= (mem_if.mem_write_data & ~flt_sa0) | flt_sa1;
            else
                mem[mem_if.mem_addr] <= mem_if.mem_write_data;
        end
        if (mem_if.mem_read_en) rdata_q <= mem[mem_if.mem_addr];
    end
    assign mem_if.mem_read_data = rdata_q;

    // ---------------- protocol monitor ----------------
    // Expected strobe n of a full March C- run, derived from the algorithm:
    // 256 writes, then four elements of (read,write) pairs, then 256 reads.
    function automatic void exp_strobe(input int n, output logic is_wr,
                                       output logic [7:0] a, output logic [7:0] wd);
        int m, e, k;
        is_wr = 1'b0; a = 8'h00; wd = 8'h00;
        if (n < 256) begin
            is_wr = 1'b1; a = 8'(n);
        end else if (n < 2304) begin
            m = n - 256;
            e = 1 + m / 512;
            k = (m % 512) / 2;
            is_wr = (m % 2) == 1;
            a = (e <= 2) ? 8'(k) : 8'(255 - k);
            wd = (e == 1 || e == 3) ? 8'hFF : 8'h00;
        end else begin
            m = n - 2304;
            a = 8'(m);
        end
    endfunction

    logic mon_en = 1'b0;
    int   sidx = 0;

    always @(negedge clk) begin
        logic       e_wr;
        logic [7:0] e_a;
        logic [7:0] e_wd;
        if (mon_en) begin
            check("strobe_exclusive", 32'(mem_if.mem_write_en & mem_if.mem_read_en), 32'd0);
            if (!busy) begin
                check("idle_quiet", 32'({mem_if.mem_write_en, mem_if.mem_read_en,
                                         mem_if.mem_addr, mem_if.mem_write_data}), 32'd0);
                sidx = 0;
            end else if (mem_if.mem_write_en || mem_if.mem_read_en) begin
                exp_strobe(sidx, e_wr, e_a, e_wd);
                check("strobe_order",
                      32'({mem_if.mem_write_en, mem_if.mem_addr,
                           mem_if.mem_write_en ? mem_if.mem_write_data : 8'h00}),
                      32'({e_wr, e_a, e_wr ? e_wd : 8'h00}));
                sidx++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic fill_mem(input logic [7:0] v);
        fill_val = v;
        fill_req = 1'b1;
        @(posedge clk);
        #1 fill_req = 1'b0;
    endtask

    // Counts busy cycles (sampled on negedges) until busy drops; optionally
    // raises start for one edge at busy cycle poke_at.
    task automatic wait_done(input int n0, input int poke_at, output int n);
        n = n0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            start = (n == poke_at);
            if (n > 5000) begin
                check("busy_timeout", 32'(n), 32'd3840);
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic set_fault(input logic [7:0] a, input logic [7:0] s1, input logic [7:0] s0);
        flt_addr = a; flt_sa1 = s1; flt_sa0 = s0;
    endtask

    typedef struct {
        logic [7:0] f_addr;
        logic [7:0] sa1;
        logic [7:0] sa0;
        logic       exp_fail;
        logic [2:0] exp_elem;
        logic [7:0] exp_addr;
        logic [7:0] exp_data;
        int         exp_cycles;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n;
        int nz;

        // Hand-computed: element 1 address a is READ at busy cycle 257+3a,
        // element 2 address a is READ at 1025+3a; CHECK follows one cycle later.
        vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 3840};
        vecs[1] = '{8'h2A, 8'h08, 8'h00, 1'b1, 3'd1, 8'h2A, 8'h08, 384};
        vecs[2] = '{8'hFF, 8'h00, 8'h80, 1'b1, 3'd2, 8'hFF, 8'h7F, 1791};
        vecs[3] = '{8'h00, 8'h01, 8'h00, 1'b1, 3'd1, 8'h00, 8'h01, 258};
        vecs[4] = '{8'h80, 8'h00, 8'h01, 1'b1, 3'd2, 8'h80, 8'hFE, 1410};
        vecs[5] = '{8'h00, 8'h00, 8'h10, 1'b1, 3'd2, 8'h00, 8'hEF, 1026};

        rst = 1'b1; start = 1'b0; fill_req = 1'b0; fill_val = 8'h00;
        set_fault(8'h00, 8'h00, 8'h00);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_status", 32'({busy, done, fail}), 32'd0);
        check("reset_diag", 32'({fail_addr, fail_data, fail_elem}), 32'd0);
        check("reset_mem_port", 32'({mem_if.mem_write_en, mem_if.mem_read_en,
                                     mem_if.mem_addr, mem_if.mem_write_data}), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_start", 32'({busy, done}), 32'd0);

        // Table-driven fault vectors
        for (int v = 0; v < 6; v++) begin
            set_fault(vecs[v].f_addr, vecs[v].sa1, vecs[v].sa0);
            fill_mem(8'hA5);
            pulse_start();
            wait_done(0, 0, n);
            check($sformatf("v%0d_cycles", v), 32'(n), 32'(vecs[v].exp_cycles));
            check($sformatf("v%0d_done", v), 32'(done), 32'd1);
            check($sformatf("v%0d_fail", v), 32'(fail), 32'(vecs[v].exp_fail));
            check($sformatf("v%0d_elem", v), 32'(fail_elem), 32'(vecs[v].exp_elem));
            check($sformatf("v%0d_addr", v), 32'(fail_addr), 32'(vecs[v].exp_addr));
            check($sformatf("v%0d_data", v), 32'(fail_data), 32'(vecs[v].exp_data));
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_done_held", v), 32'({done, busy}), 32'b10);
            if (!vecs[v].exp_fail) begin
                nz = 0;
                for (int i = 0; i < 256; i++) if (mem[i] != 8'h00) nz++;
                check("final_background_zero", 32'(nz), 32'd0);
            end
        end

        // start pulsed mid-run is ignored
        set_fault(8'h00, 8'h00, 8'h00);
        pulse_start();
        wait_done(0, 500, n);
        check("busy_start_ignored_cycles", 32'(n), 32'd3840);
        check("busy_start_ignored_result", 32'({done, fail}), 32'b10);

        // Asynchronous reset mid-run, then a full clean rerun
        pulse_start();
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            if (busy) n++;
            else begin
                check("busy_before_reset", 32'(busy), 32'd1);
                break;
            end
        end
        rst = 1'b1;
        #1;
        check("midreset_status", 32'({busy, done, fail}), 32'd0);
        check("midreset_mem_port", 32'({mem_if.mem_write_en, mem_if.mem_read_en,
                                        mem_if.mem_addr, mem_if.mem_write_data}), 32'd0);
        check("midreset_diag", 32'({fail_addr, fail_data, fail_elem}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        pulse_start();
        wait_done(0, 0, n);
        check("post_reset_cycles", 32'(n), 32'd3840);
        check("post_reset_result", 32'({done, fail}), 32'b10);

        // Restart from DONE after a failure clears status and reruns
        set_fault(8'h2A, 8'h08, 8'h00);
        pulse_start();
        wait_done(0, 0, n);
        check("fail_run_result", 32'({done, fail, fail_elem}), 32'({1'b1, 1'b1, 3'd1}));
        pulse_start();
        @(negedge clk);
        check("restart_status", 32'({busy, done, fail}), 32'b100);
        check("restart_diag_clear", 32'({fail_addr, fail_data, fail_elem}), 32'd0);
        wait_done(1, 0, n);
        check("rerun_cycles", 32'(n), 32'd384);
        check("rerun_diag", 32'({fail, fail_elem, fail_addr, fail_data}),
              32'({1'b1, 3'd1, 8'h2A, 8'h08}));

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bist_march.md
# mem_bist_march

March C- memory built-in self-test controller that sits directly upstream of the 256×8 test memory and owns its write/read/address/data ports during a test. On a `start` pulse it runs six march elements over the full address space. Each read result is compared against the expected background, and the controller reports pass/fail plus first-failure diagnostics to the JTAG test data register. The test is destructive: memory contents are not preserved.

## Interface
- `ADDR_W`, default 8: memory address width; depth = 2**ADDR_W.
- `DATA_W`, default 8: memory word width; backgrounds are all-0 / all-1.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: one-cycle request; honoured only in IDLE or DONE.
- `mem_write_en` out 1: memory write strobe.
- `mem_read_en` out 1: memory read strobe.
- `mem_addr` out ADDR_W: memory address.
- `mem_write_data` out DATA_W: memory write data.
- `mem_read_data` in DATA_W: memory registered read data; valid the cycle after `mem_read_en`.
- `busy` out 1: test in progress.
- `done` out 1: test finished; held until next `start` or reset.
- `fail` out 1: mismatch detected; valid when `done`.
- `fail_addr` out ADDR_W: address of first mismatch.
- `fail_data` out DATA_W: data read at first mismatch.
- `fail_elem` out 3: march element index (0–5) of first mismatch.

## Operation
- March elements, indexed 0–5:
  - 0: ⇑(w0)
  - 1: ⇑(r0,w1)
  - 2: ⇑(r1,w0)
  - 3: ⇓(r0,w1)
  - 4: ⇓(r1,w0)
  - 5: ⇑(r0)
- ⇑ means address 0→DEPTH-1; ⇓ means DEPTH-1→0. The element ends on the terminal address; there is no wrap.
- States and transitions:
  - IDLE —`start`→ WRITE (element 0, address 0).
  - WRITE: the element's write op at the current address.
  - READ: the element's read op at the current address.
  - CHECK: compare `mem_read_data` against the expected value (0 or all-ones).
  - Per-element op sequence:
    - Element 0: WRITE per address.
    - Elements 1–4: READ → CHECK → WRITE per address.
    - Element 5: READ → CHECK per address.
  - After the last op at the terminal address, move to the next element's first op and reload the address (0 or DEPTH-1).
  - Last CHECK of element 5 passes → DONE with `fail`=0.
  - Any CHECK mismatch → DONE immediately with `fail`=1; latch `fail_addr`, `fail_data`, `fail_elem`.
  - DONE —`start`→ WRITE (element 0, address 0); clear `fail` and diagnostics.
- `mem_*` outputs are decoded from the state register and address counter.
  - `mem_write_en`=1 only in WRITE; `mem_read_en`=1 only in READ. Both are never high together.
  - Both are 0 in IDLE, CHECK and DONE. `mem_addr` and `mem_write_data` are 0 in IDLE and DONE.
- `start` during WRITE, READ or CHECK is ignored.
- The controller never drives memory reset.

## Timing
- Reset values: all outputs 0; state IDLE. `rst` takes effect without a clock edge, including mid-test; a subsequent `start` runs the full test.
- `start` high at edge E → first WRITE cycle, with `busy`=1, immediately after E.
- Read latency: READ at cycle k (address a); memory captures at the end of k; CHECK at k+1 samples `mem_read_data`.
- Passing run: `busy` high for exactly 256 + 4×768 + 512 = 3840 cycles at DEPTH=256. `done` rises and `busy` falls in the same cycle, directly after the final CHECK.
- Failing run: `done`/`fail` assert in the cycle after the failing CHECK; diagnostics are stable from that cycle.

## Structure
- `mem_bist_pkg`:
  - state enum.
  - element count constant (6).
  - march table, per element: direction, has_read, read expected value, has_write, write value.
- Sub-module `mem_bist_addr_gen`: loadable up/down address counter with a terminal-address flag, stepped by the FSM.
- FSM, comparator and diagnostic registers live in the top module.

## Test plan
- Clean memory, `start` pulse → `busy` for 3840 cycles; then `done`=1, `fail`=0; all 256 locations read back 0x00.
- Bit 3 of address 0x2A stuck at 1 → `done` in busy-cycle 385; `fail`=1, `fail_elem`=1, `fail_addr`=0x2A, `fail_data`=0x08.
- Bit 7 of address 0xFF stuck at 0 → `fail_elem`=2, `fail_addr`=0xFF, `fail_data`=0x7F.
- Protocol monitor over a full run:
  - `mem_read_en` and `mem_write_en` never both high.
  - No strobes in IDLE/DONE.
  - Address order is ascending in elements 0–2 and 5, descending in elements 3–4.
- `rst` asserted mid-cycle at busy-cycle 1000 → all outputs 0 before the next edge; a new `start` gives a full 3840-cycle pass.
- `start` pulsed during busy → ignored, cycle count unchanged. `start` pulsed in DONE after a fail → `fail`/`done` clear, `busy` rises the next cycle, and the test reruns.
